// File: rtl/mulu_m2q2_seq_if.sv
// Operand/result valid-ready bundle for mulu_m2q2_seq.
// The master drives operands and result readiness; the multiplier is the slave.
interface mulu_m2q2_seq_if #(
    parameter int WIDTH = 8
) ();
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/mulu_m2q2_seq.sv
// Unsigned WIDTHxWIDTH multiplier that time-shares one external 2x2 core,
// feeding it one digit pair per cycle and accumulating shifted partial products.
module mulu_m2q2_seq #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    mulu_m2q2_seq_if.slave      bus,
    output logic                busy,
    output logic [1:0]          mul_x,
    output logic [1:0]          mul_y,
    input  logic [3:0]          mul_p
);
    localparam int D  = WIDTH / 2;
    localparam int N  = D * D;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  xr_q, xr_d;
    logic [WIDTH-1:0]  yr_q, yr_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     p_q, p_d;
    logic [PW-1:0]     term;
    logic [KW-1:0]     k_q, k_d;
    int unsigned       i_idx;
    int unsigned       j_idx;

    always_comb begin
        // NOTE: every signal written here is defaulted first, so no branch can infer a latch.
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        acc_d   = acc_q;
        p_d     = p_q;
        k_d     = k_q;
        term    = '0;
        mul_x   = '0;
        mul_y   = '0;
        // x digit index varies fastest as k advances
        i_idx   = 32'(k_q) % D;
        j_idx   = 32'(k_q) / D;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    xr_d    = bus.x;
                    yr_d    = bus.y;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                mul_x = 2'(xr_q >> (2 * i_idx));
                mul_y = 2'(yr_q >> (2 * j_idx));
                term  = PW'(mul_p) << (2 * (i_idx + j_idx));
                acc_d = acc_q + term;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(N - 1)) begin
                    p_d     = acc_d;
                    k_d     = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            k_q     <= k_d;
        end
    end

    // in_ready is gated by rst so no operand is ever offered during reset
    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.p         = p_q;
    assign busy          = (state_q == S_RUN);
endmodule

// File: tb/tb_mulu_m2q2_seq.sv
// Scoreboard bench for mulu_m2q2_seq at WIDTH=8 (directed + burst) and WIDTH=2/6 (burst).
// The 2x2 core is modelled here as a plain combinational multiply.
module tb_mulu_m2q2_seq;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_s = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] p;
        int          c0;
    } exp_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h) at cycle %0d",
                     name, got, got, exp, exp, cyc);
        end
    endtask

    // ---------------- WIDTH=8 instance ----------------
    mulu_m2q2_seq_if #(.WIDTH(8)) b8 ();
    logic       busy8;
    logic [1:0] mx8, my8;
    logic [3:0] mp8;
    assign mp8 = {2'b00, mx8} * {2'b00, my8};
    mulu_m2q2_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .bus(b8.slave),
        .busy(busy8), .mul_x(mx8), .mul_y(my8), .mul_p(mp8)
    );

    // ---------------- WIDTH=2 instance ----------------
    mulu_m2q2_seq_if #(.WIDTH(2)) b2 ();
    logic       busy2;
    logic [1:0] mx2, my2;
    logic [3:0] mp2;
    assign mp2 = {2'b00, mx2} * {2'b00, my2};
    mulu_m2q2_seq #(.WIDTH(2)) u2 (
        .clk(clk), .rst(rst_s), .bus(b2.slave),
        .busy(busy2), .mul_x(mx2), .mul_y(my2), .mul_p(mp2)
    );

    // ---------------- WIDTH=6 instance ----------------
    mulu_m2q2_seq_if #(.WIDTH(6)) b6 ();
    logic       busy6;
    logic [1:0] mx6, my6;
    logic [3:0] mp6;
    assign mp6 = {2'b00, mx6} * {2'b00, my6};
    mulu_m2q2_seq #(.WIDTH(6)) u6 (
        .clk(clk), .rst(rst_s), .bus(b6.slave),
        .busy(busy6), .mul_x(mx6), .mul_y(my6), .mul_p(mp6)
    );

    exp_t q8[$];
    exp_t q2[$];
    exp_t q6[$];
    exp_t e8, e2, e6;

    bit   burst8    = 1'b0;
    int   last_c0_8 = -1;
    int   last_c0_2 = -1;
    int   last_c0_6 = -1;
    bit   done2     = 1'b0;
    bit   done6     = 1'b0;

    // ---------------- drivers (called at a falling edge) ----------------
    task automatic send8(input logic [7:0] xv, input logic [7:0] yv,
                         input logic [15:0] ev, input bit push);
        int n = 0;
        b8.in_valid = 1'b1;
        b8.x        = xv;
        b8.y        = yv;
        while (!b8.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("w8_accept", b8.in_ready, 1);
        if (!b8.in_ready) begin
            b8.in_valid = 1'b0;
            return;
        end
        if (push) q8.push_back(exp_t'{ev, cyc + 1});
        if (burst8 && last_c0_8 >= 0) check("w8_throughput", cyc + 1 - last_c0_8, 18);
        last_c0_8 = cyc + 1;
        @(negedge clk);
        b8.in_valid = 1'b0;
    endtask

    task automatic send2(input logic [1:0] xv, input logic [1:0] yv);
        int n = 0;
        b2.in_valid = 1'b1;
        b2.x        = xv;
        b2.y        = yv;
        while (!b2.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w2_accept", b2.in_ready, 1);
        if (!b2.in_ready) begin
            b2.in_valid = 1'b0;
            return;
        end
        q2.push_back(exp_t'{16'(xv) * 16'(yv), cyc + 1});
        if (last_c0_2 >= 0) check("w2_throughput", cyc + 1 - last_c0_2, 3);
        last_c0_2 = cyc + 1;
        @(negedge clk);
        b2.in_valid = 1'b0;
    endtask

    task automatic send6(input logic [5:0] xv, input logic [5:0] yv);
        int n = 0;
        b6.in_valid = 1'b1;
        b6.x        = xv;
        b6.y        = yv;
        while (!b6.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("w6_accept", b6.in_ready, 1);
        if (!b6.in_ready) begin
            b6.in_valid = 1'b0;
            return;
        end
        q6.push_back(exp_t'{16'(xv) * 16'(yv), cyc + 1});
        if (last_c0_6 >= 0) check("w6_throughput", cyc + 1 - last_c0_6, 11);
        last_c0_6 = cyc + 1;
        @(negedge clk);
        b6.in_valid = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("w8_drain", q8.size(), 0);
    endtask

    // ---------------- monitors (just after the falling edge) ----------------
    bit          ov8_prev = 1'b0;
    logic [15:0] p8_prev;
    int          busy8_cnt = 0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            ov8_prev  = 1'b0;
            busy8_cnt = 0;
        end else begin
            if (busy8) busy8_cnt++;
            if (b8.out_valid) begin
                check("w8_in_ready_in_done", b8.in_ready, 0);
                if (!ov8_prev) begin
                    if (q8.size() == 0) begin
                        check("w8_unexpected_out_valid", q8.size(), 1);
                    end else begin
                        check("w8_latency", cyc - q8[0].c0 + 1, 17);
                        check("w8_busy_cycles", busy8_cnt, 16);
                    end
                    busy8_cnt = 0;
                end else begin
                    check("w8_p_stable", b8.p, p8_prev);
                end
                if (b8.out_ready && q8.size() > 0) begin
                    e8 = q8.pop_front();
                    check("w8_product", b8.p, e8.p);
                end
            end
            ov8_prev = b8.out_valid;
            p8_prev  = b8.p;
        end
    end

    bit ov2_prev = 1'b0;
    bit ov6_prev = 1'b0;

    always @(negedge clk) begin
        #1;
        if (!rst_s) begin
            if (b2.out_valid) begin
                if (q2.size() == 0) check("w2_unexpected_out_valid", q2.size(), 1);
                else begin
                    if (!ov2_prev) check("w2_latency", cyc - q2[0].c0 + 1, 2);
                    if (b2.out_ready) begin
                        e2 = q2.pop_front();
                        check("w2_product", b2.p, e2.p[3:0]);
                    end
                end
            end
            if (b6.out_valid) begin
                if (q6.size() == 0) check("w6_unexpected_out_valid", q6.size(), 1);
                else begin
                    if (!ov6_prev) check("w6_latency", cyc - q6[0].c0 + 1, 10);
                    if (b6.out_ready) begin
                        e6 = q6.pop_front();
                        check("w6_product", b6.p, e6.p[11:0]);
                    end
                end
            end
            ov2_prev = b2.out_valid;
            ov6_prev = b6.out_valid;
        end
    end

    // ---------------- small-width burst stimulus ----------------
    initial begin
        b2.in_valid = 1'b0; b2.x = '0; b2.y = '0; b2.out_ready = 1'b1;
        b6.in_valid = 1'b0; b6.x = '0; b6.y = '0; b6.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_s = 1'b0;
        @(negedge clk);
        fork
            begin
                int n = 0;
                send2(2'd3, 2'd3);
                send2(2'd0, 2'd2);
                for (int i = 0; i < 98; i++) send2(2'($urandom), 2'($urandom));
                while (q2.size() > 0 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                done2 = 1'b1;
            end
            begin
                int n = 0;
                send6(6'd63, 6'd63);
                send6(6'd0, 6'd45);
                for (int i = 0; i < 98; i++) send6(6'($urandom), 6'($urandom));
                while (q6.size() > 0 && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                done6 = 1'b1;
            end
        join
    end

    // ---------------- WIDTH=8 directed and burst stimulus ----------------
    initial begin
        logic [7:0] rx, ry;
        int n;
        b8.in_valid = 1'b0; b8.x = '0; b8.y = '0; b8.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", b8.in_ready, 0);
        check("rst_out_valid", b8.out_valid, 0);
        check("rst_busy", busy8, 0);
        check("rst_p", b8.p, 0);
        check("rst_mul_x", mx8, 0);
        check("rst_mul_y", my8, 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", b8.in_ready, 1);

        // Basic product; operands change after acceptance
        send8(8'h0D, 8'h0B, 16'h008F, 1'b1);
        b8.x = 8'h5A;
        b8.y = 8'hC3;
        drain8();

        // Maximum operands
        send8(8'hFF, 8'hFF, 16'hFE01, 1'b1);
        drain8();

        // Core digit sequence: x digits 0,1,2,3 low first
        send8(8'hE4, 8'h01, 16'h00E4, 1'b1);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("digit_mul_x_k%0d", k), mx8, k % 4);
            check($sformatf("digit_mul_y_k%0d", k), my8, (k < 4) ? 1 : 0);
            @(negedge clk);
        end
        drain8();

        // Reset mid-run at k=7
        send8(8'h37, 8'h5C, 16'h0000, 1'b0);
        repeat (7) @(negedge clk);
        check("mid_run_busy", busy8, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", b8.in_ready, 0);
        check("midrst_out_valid", b8.out_valid, 0);
        check("midrst_busy", busy8, 0);
        check("midrst_p", b8.p, 0);
        check("midrst_mul_x", mx8, 0);
        check("midrst_mul_y", my8, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_idle", b8.in_ready, 1);
        send8(8'h03, 8'h02, 16'h0006, 1'b1);
        drain8();

        // Zero operand with 5 cycles of backpressure and an ignored in_valid pulse
        b8.out_ready = 1'b0;
        send8(8'h00, 8'hA7, 16'h0000, 1'b1);
        n = 0;
        while (!b8.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", b8.out_valid, 1);
        for (int s = 0; s < 5; s++) begin
            b8.in_valid = (s == 2);
            b8.x        = 8'h55;
            b8.y        = 8'h55;
            check("bp_in_ready", b8.in_ready, 0);
            check("bp_p", b8.p, 0);
            @(negedge clk);
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", b8.out_valid, 0);
        check("bp_release_in_ready", b8.in_ready, 1);
        check("bp_release_p", b8.p, 0);
        drain8();

        // Back-to-back random products
        burst8    = 1'b1;
        last_c0_8 = -1;
        for (int i = 0; i < 1000; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            send8(rx, ry, 16'(rx) * 16'(ry), 1'b1);
        end
        burst8 = 1'b0;
        drain8();

        n = 0;
        while (!(done2 && done6) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("small_widths_done", {done2, done6}, 2'b11);
        check("w2_queue_empty", q2.size(), 0);
        check("w6_queue_empty", q6.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mulu_m2q2_seq.md
# mulu_m2q2_seq

Sequential controller that computes an unsigned WIDTH×WIDTH product using one shared 2×2 unsigned multiplier core (`mulu_m2q2`). The block latches two operands, walks every pair of 2-bit digits through the core one pair per cycle, and accumulates the shifted 4-bit partial products into a 2·WIDTH-bit result. It sits between a valid/ready operand source and a valid/ready result sink. The combinational core is instantiated outside this block and connected through the `mul_*` ports.

## Interface

Parameters:

- `WIDTH`, default 8: operand width. Must be even and ≥2. Define D = WIDTH/2 (digits per operand) and N = D·D (run cycles).

Ports:

- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: operands `x`/`y` are valid.
- `in_ready`, output, 1: block accepts operands.
- `x`, input, WIDTH: unsigned multiplicand.
- `y`, input, WIDTH: unsigned multiplier.
- `out_valid`, output, 1: `p` holds a completed product.
- `out_ready`, input, 1: sink accepts `p`.
- `p`, output, 2·WIDTH: product register.
- `busy`, output, 1: high in RUN.
- `mul_x`, output, 2: digit to core `x`.
- `mul_y`, output, 2: digit to core `y`.
- `mul_p`, input, 4: core product, combinational from `mul_x`/`mul_y` in the same cycle.

## Operation

States:

- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `x`→xr and `y`→yr, clear acc, set k=0, go to RUN.
- RUN:
  - k counts 0..N-1. Define i = k mod D and j = k div D (x digit varies fastest).
  - `mul_x` = xr[2i+1:2i] and `mul_y` = yr[2j+1:2j].
  - Each edge: acc ← acc + (`mul_p` << 2·(i+j)), k ← k+1.
  - On the edge where k=N-1: p ← final acc value (including this cycle's term), go to DONE.
- DONE:
  - `out_valid`=1 and `p` is held stable.
  - On `out_valid`&&`out_ready`: go to IDLE; `p` keeps its value.

Output rules:

- `in_ready` is asserted only in IDLE and never while `rst`=1.
- `in_valid` outside IDLE is ignored; operands are not queued.
- `mul_x`/`mul_y` are 0 outside RUN.
- `busy` is high exactly in RUN.

Arithmetic and width:

- acc is 2·WIDTH bits, zero-extended.
- Each partial product is ≤9 and its shift is ≤2·WIDTH-4, so the final sum is ≤(2^WIDTH−1)² and never overflows. No saturation or wrap logic is needed.
- k is ⌈log2 N⌉ bits wide, with a minimum of 1 bit.
- WIDTH=2 gives N=1: a single RUN cycle.

Boundary conditions:

- Reset in any state returns to IDLE and clears acc and k. Any in-flight operation is abandoned and produces no `out_valid`.
- A new operation cannot start in DONE, even when `out_ready` is high.
- `x`/`y` changing after acceptance has no effect, because the latched copies are used.
- `out_ready` outside DONE has no effect.

Reset values:

- `in_ready`=0 (1 from the first cycle after `rst` deasserts).
- `out_valid`=0, `busy`=0, `p`=0, `mul_x`=0, `mul_y`=0.
- State = IDLE, acc=0, k=0.

## Timing

- Acceptance edge = E0.
- RUN occupies cycles 1..N after E0. `mul_x`/`mul_y` for run index k are presented in cycle k+1.
- `out_valid` rises in cycle N+1 after E0. This is 17 cycles for WIDTH=8.
- With `out_ready` held high, `out_valid` is high for exactly 1 cycle, `in_ready` returns in cycle N+2, and throughput is one product per N+2 cycles.
- Backpressure holds DONE indefinitely with `p` stable.
- `mul_p` is sampled at the same edge that advances k. There is no pipeline stage in the core path.

## Test plan

- **Basic product**: WIDTH=8, x=0x0D, y=0x0B, `out_ready`=1. Expect `p`=0x008F with `out_valid` exactly 17 cycles after acceptance. `busy` is high for 16 cycles.
- **Maximum operands**: x=0xFF, y=0xFF. Expect `p`=0xFE01 (no overflow).
- **Core digit sequence**: x=0xE4, y=0x01.
  - k=0..3: `mul_x`=0,1,2,3 and `mul_y`=1.
  - k=4..15: `mul_x` cycles 0,1,2,3 with `mul_y`=0.
  - Expect `p`=0x00E4.
- **Zero and backpressure**: x=0x00, y=0xA7, `out_ready`=0 for 5 cycles after `out_valid`.
  - Expect `p`=0 held stable and `in_ready`=0 throughout.
  - A new `in_valid` pulse during the stall is ignored.
  - Raising `out_ready` gives IDLE next cycle.
- **Reset mid-run**: accept x=0x37, y=0x5C, assert `rst` at k=7.
  - Expect IDLE, `p`=0, `out_valid`=0, `mul_x`/`mul_y`=0 next cycle.
  - A following x=0x03, y=0x02 yields `p`=0x0006.
- **Back-to-back random**: 1000 random operand pairs at WIDTH=8, plus 100 at WIDTH=2 (N=1, latency 2) and WIDTH=6. Check `p` equals x·y and throughput is one product per N+2 cycles.
